// File: rtl/branch_predictor.sv
// rtl/branch_predictor.sv - direct-mapped dynamic branch predictor; optional stats via BRANCH_PRED_STATS_EN
module branch_predictor #(
    parameter int ADDR_W  = 32,
    parameter int ENTRIES = 16,
    parameter int CNT_W   = 2,
    parameter int TAG_W   = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic              lookup_valid_i,
    input  logic [ADDR_W-1:0] lookup_pc_i,
    output logic              pred_hit_o,
    output logic              pred_taken_o,
    output logic [ADDR_W-1:0] pred_target_o,
    input  logic              upd_valid_i,
    input  logic [ADDR_W-1:0] upd_pc_i,
    input  logic              upd_taken_i,
    input  logic [ADDR_W-1:0] upd_target_i,
    input  logic              upd_mispredict_i,
    output logic [31:0]       lookup_cnt_o,
    output logic [31:0]       upd_cnt_o,
    output logic [31:0]       mispred_cnt_o
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] CNT_ALLOC = CNT_W'(1 << (CNT_W - 1));
    localparam logic [CNT_W-1:0] CNT_RST   = CNT_W'((1 << (CNT_W - 1)) - 1);

    logic              valid_q  [ENTRIES];
    logic [TAG_W-1:0]  tag_q    [ENTRIES];
    logic [ADDR_W-1:0] target_q [ENTRIES];
    logic [CNT_W-1:0]  cnt_q    [ENTRIES];

    logic [IDX_W-1:0] lk_idx;
    logic [TAG_W-1:0] lk_tag;
    logic [IDX_W-1:0] up_idx;
    logic [TAG_W-1:0] up_tag;
    logic             up_hit;
    logic [CNT_W-1:0] cnt_next;
    logic             unused;

    assign lk_idx = lookup_pc_i[IDX_W+1:2];
    assign lk_tag = lookup_pc_i[IDX_W+TAG_W+1:IDX_W+2];
    assign up_idx = upd_pc_i[IDX_W+1:2];
    assign up_tag = upd_pc_i[IDX_W+TAG_W+1:IDX_W+2];

    // Lookup reads the registered table only, so a same-cycle update is never bypassed
    assign pred_hit_o    = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    assign pred_taken_o  = pred_hit_o && cnt_q[lk_idx][CNT_W-1];
    assign pred_target_o = pred_taken_o ? target_q[lk_idx] : lookup_pc_i + ADDR_W'(4);

    assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);

    always_comb begin
        cnt_next = cnt_q[up_idx];
        if (upd_taken_i) begin
            if (cnt_q[up_idx] != CNT_MAX) begin
                cnt_next = cnt_q[up_idx] + CNT_W'(1);
            end
        end else if (cnt_q[up_idx] != '0) begin
            cnt_next = cnt_q[up_idx] - CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
                cnt_q[i]   <= CNT_RST;
            end
        end else if (flush_i) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
                cnt_q[i]   <= CNT_RST;
            end
        end else if (upd_valid_i) begin
            if (up_hit) begin
                cnt_q[up_idx] <= cnt_next;
            end else if (upd_taken_i) begin
                valid_q[up_idx] <= 1'b1;
                cnt_q[up_idx]   <= CNT_ALLOC;
            end
        end
    end

    // Tags and targets only matter behind a set valid bit, so they carry no reset
    always_ff @(posedge clk_i) begin
        if (!flush_i && upd_valid_i && upd_taken_i) begin
            tag_q[up_idx]    <= up_tag;
            target_q[up_idx] <= upd_target_i;
        end
    end

`ifdef BRANCH_PRED_STATS_EN
    logic [31:0] lookup_cnt_q;
    logic [31:0] upd_cnt_q;
    logic [31:0] mispred_cnt_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            lookup_cnt_q  <= '0;
            upd_cnt_q     <= '0;
            mispred_cnt_q <= '0;
        end else begin
            if (lookup_valid_i) begin
                lookup_cnt_q <= lookup_cnt_q + 32'd1;
            end
            if (upd_valid_i) begin
                upd_cnt_q <= upd_cnt_q + 32'd1;
            end
            if (upd_valid_i && upd_mispredict_i) begin
                mispred_cnt_q <= mispred_cnt_q + 32'd1;
            end
        end
    end

    assign lookup_cnt_o  = lookup_cnt_q;
    assign upd_cnt_o     = upd_cnt_q;
    assign mispred_cnt_o = mispred_cnt_q;
    assign unused        = ^{lookup_pc_i, upd_pc_i};
`else
    assign lookup_cnt_o  = '0;
    assign upd_cnt_o     = '0;
    assign mispred_cnt_o = '0;
    assign unused        = ^{lookup_pc_i, upd_pc_i, lookup_valid_i, upd_mispredict_i};
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// tb/tb_branch_predictor.sv - directed and random checks of branch_predictor against a table model
module tb_branch_predictor;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        flush_i = 1'b0;
    logic        lookup_valid_i = 1'b0;
    logic [31:0] lookup_pc_i = '0;
    logic        pred_hit_o;
    logic        pred_taken_o;
    logic [31:0] pred_target_o;
    logic        upd_valid_i = 1'b0;
    logic [31:0] upd_pc_i = '0;
    logic        upd_taken_i = 1'b0;
    logic [31:0] upd_target_i = '0;
    logic        upd_mispredict_i = 1'b0;
    logic [31:0] lookup_cnt_o;
    logic [31:0] upd_cnt_o;
    logic [31:0] mispred_cnt_o;

    int total = 0;
    int bad = 0;

    bit          m_valid [16];
    int          m_tag   [16];
    logic [31:0] m_tgt   [16];
    int          m_cnt   [16];
    logic [31:0] m_lk, m_up, m_mp;

    always #5 clk = ~clk;

    branch_predictor dut (
        .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i),
        .lookup_valid_i(lookup_valid_i), .lookup_pc_i(lookup_pc_i),
        .pred_hit_o(pred_hit_o), .pred_taken_o(pred_taken_o), .pred_target_o(pred_target_o),
        .upd_valid_i(upd_valid_i), .upd_pc_i(upd_pc_i), .upd_taken_i(upd_taken_i),
        .upd_target_i(upd_target_i), .upd_mispredict_i(upd_mispredict_i),
        .lookup_cnt_o(lookup_cnt_o), .upd_cnt_o(upd_cnt_o), .mispred_cnt_o(mispred_cnt_o)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear(input bit stats);
        for (int i = 0; i < 16; i++) begin
            m_valid[i] = 1'b0;
            m_cnt[i]   = 1;
        end
        if (stats) begin
            m_lk = 0; m_up = 0; m_mp = 0;
        end
    endtask

    task automatic check_lookup(input string nm);
        int idx, tg;
        bit hit, tk;
        idx = int'((lookup_pc_i >> 2) % 16);
        tg  = int'((lookup_pc_i >> 6) % 256);
        hit = m_valid[idx] && (m_tag[idx] == tg);
        tk  = hit && (m_cnt[idx] >= 2);
        check({nm, "_hit"}, 32'(pred_hit_o), 32'(hit));
        check({nm, "_taken"}, 32'(pred_taken_o), 32'(tk));
        check({nm, "_target"}, pred_target_o, tk ? m_tgt[idx] : lookup_pc_i + 32'd4);
    endtask

    task automatic check_stats(input string nm);
`ifdef BRANCH_PRED_STATS_EN
        check({nm, "_lkcnt"}, lookup_cnt_o, m_lk);
        check({nm, "_upcnt"}, upd_cnt_o, m_up);
        check({nm, "_mpcnt"}, mispred_cnt_o, m_mp);
`else
        check({nm, "_lkcnt"}, lookup_cnt_o, 32'd0);
        check({nm, "_upcnt"}, upd_cnt_o, 32'd0);
        check({nm, "_mpcnt"}, mispred_cnt_o, 32'd0);
`endif
    endtask

    // Applies the documented update rules for whatever inputs were present at the edge
    task automatic model_clock();
        int idx, tg;
        if (lookup_valid_i) m_lk++;
        if (upd_valid_i) m_up++;
        if (upd_valid_i && upd_mispredict_i) m_mp++;
        if (flush_i) begin
            model_clear(1'b0);
        end else if (upd_valid_i) begin
            idx = int'((upd_pc_i >> 2) % 16);
            tg  = int'((upd_pc_i >> 6) % 256);
            if (m_valid[idx] && m_tag[idx] == tg) begin
                if (upd_taken_i) begin
                    if (m_cnt[idx] < 3) m_cnt[idx]++;
                    m_tgt[idx] = upd_target_i;
                end else if (m_cnt[idx] > 0) begin
                    m_cnt[idx]--;
                end
            end else if (upd_taken_i) begin
                m_valid[idx] = 1'b1;
                m_tag[idx]   = tg;
                m_tgt[idx]   = upd_target_i;
                m_cnt[idx]   = 2;
            end
        end
    endtask

    task automatic tick(input string nm);
        #1;
        check_lookup(nm);
        check_stats(nm);
        @(posedge clk);
        #0 model_clock();
        @(negedge clk);
    endtask

    task automatic idle();
        flush_i = 0; lookup_valid_i = 0; upd_valid_i = 0;
        upd_taken_i = 0; upd_mispredict_i = 0;
    endtask

    task automatic upd(input logic [31:0] pc, input bit tk, input logic [31:0] tgt, input string nm);
        upd_valid_i = 1; upd_pc_i = pc; upd_taken_i = tk; upd_target_i = tgt;
        lookup_pc_i = pc;
        tick(nm);
        idle();
    endtask

    task automatic look(input logic [31:0] pc, input string nm);
        lookup_pc_i = pc;
        tick(nm);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        #2 rst_i = 1;
        #1 model_clear(1'b1);
        @(negedge clk);
        rst_i = 0;
        idle();
    endtask

    logic [31:0] pool [8];

    initial begin
        model_clear(1'b1);
        lookup_pc_i = 32'h40;
        #2;
        check("rst_hit", 32'(pred_hit_o), 32'd0);
        check("rst_taken", 32'(pred_taken_o), 32'd0);
        check("rst_target", pred_target_o, 32'h44);
        check_stats("rst");
        @(negedge clk);
        rst_i = 0;
        look(32'h40, "post_rst");

        upd(32'h40, 1, 32'h20, "alloc");
        lookup_pc_i = 32'h40;
        #1;
        check("alloc_hit", 32'(pred_hit_o), 32'd1);
        check("alloc_taken", 32'(pred_taken_o), 32'd1);
        check("alloc_target", pred_target_o, 32'h20);
        @(negedge clk);

        for (int i = 0; i < 3; i++) upd(32'h40, 0, 32'h0, "sat_nt");
        lookup_pc_i = 32'h40;
        #1;
        check("sat_low_taken", 32'(pred_taken_o), 32'd0);
        check("sat_low_target", pred_target_o, 32'h44);
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            upd(32'h40, 1, 32'h20, "sat_t");
            look(32'h40, "sat_t_look");
        end
        upd(32'h40, 0, 32'h0, "sat_hi_nt");
        look(32'h40, "sat_hi_look");

        upd(32'h440, 1, 32'h100, "alias");
        lookup_pc_i = 32'h40;
        #1 check("alias_old_hit", 32'(pred_hit_o), 32'd0);
        lookup_pc_i = 32'h440;
        #1 check("alias_new_taken", 32'(pred_taken_o), 32'd1);
        check("alias_new_target", pred_target_o, 32'h100);
        @(negedge clk);
        upd(32'h844, 0, 32'h0, "miss_nt");
        look(32'h844, "miss_nt_look");
        look(32'h440, "alias_keep");

        upd_valid_i = 1; upd_pc_i = 32'h80; upd_taken_i = 1; upd_target_i = 32'h200;
        lookup_pc_i = 32'h80;
        #1 check("same_cycle_hit", 32'(pred_hit_o), 32'd0);
        tick("same_cycle");
        idle();
        #1 check("next_cycle_hit", 32'(pred_hit_o), 32'd1);
        @(negedge clk);

        flush_i = 1;
        upd(32'hC0, 1, 32'h300, "flush_upd");
        look(32'hC0, "flush_c0");
        look(32'h80, "flush_80");
        look(32'h440, "flush_440");

        upd(32'h40, 1, 32'h20, "pre_rst");
        upd_valid_i = 1; upd_pc_i = 32'h80; upd_taken_i = 1; upd_target_i = 32'h200;
        lookup_pc_i = 32'h40;
        pulse_reset();
        look(32'h40, "midrst_40");
        look(32'h80, "midrst_80");

        pulse_reset();
        lookup_valid_i = 1;
        for (int i = 0; i < 5; i++) look(32'h10 * i, "stats_lk");
        lookup_valid_i = 0;
        upd(32'h100, 1, 32'h8, "stats_u0");
        upd_mispredict_i = 1;
        upd(32'h104, 0, 32'h0, "stats_u1");
        upd(32'h108, 1, 32'hC, "stats_u2");
`ifdef BRANCH_PRED_STATS_EN
        check("stats_lk5", lookup_cnt_o, 32'd5);
        check("stats_up3", upd_cnt_o, 32'd3);
        check("stats_mp1", mispred_cnt_o, 32'd1);
`else
        check("stats_lk0", lookup_cnt_o, 32'd0);
        check("stats_up0", upd_cnt_o, 32'd0);
        check("stats_mp0", mispred_cnt_o, 32'd0);
`endif
        flush_i = 1;
        look(32'h100, "stats_flush");
        idle();
        look(32'h100, "stats_after_flush");

        for (int i = 0; i < 8; i++) begin
            pool[i] = (32'($urandom_range(0, 2)) << 6) | (32'($urandom_range(0, 3)) << 2);
        end
        for (int n = 0; n < 400; n++) begin
            lookup_valid_i   = 1'($urandom_range(0, 1));
            upd_valid_i      = ($urandom_range(0, 3) != 0);
            upd_taken_i      = 1'($urandom_range(0, 1));
            upd_mispredict_i = 1'($urandom_range(0, 1));
            flush_i          = ($urandom_range(0, 24) == 0);
            upd_pc_i         = pool[$urandom_range(0, 7)] | (32'($urandom_range(0, 3)) << 14);
            upd_target_i     = $urandom & 32'hFFFF_FFFC;
            lookup_pc_i      = ($urandom_range(0, 3) == 0) ? upd_pc_i : pool[$urandom_range(0, 7)];
            tick("rand");
        end
        idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
